cmp2_bist: RTL
==============

CMP2_BIST -- requirements
Module: cmp2_bist

Interface
REQ-001 SETTLE, default 1, cycles to wait after driving a vector before sampling the comparator outputs; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin a self-test run.
REQ-005 x_o  output  2  operand x driven to the comparator under test.
REQ-006 y_o  output  2  operand y driven to the comparator under test.
REQ-007 g_i  input  1  comparator "greater" result (x>y).
REQ-008 l_i  input  1  comparator "less" result (x<y).
REQ-009 e_i  input  1  comparator "equal" result (x==y).
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next accepted start or reset.
REQ-012 pass  output  1  high only when done=1 and err_cnt=0.
REQ-013 err_cnt  output  5  number of failing vectors in the current or last run (0..16).
REQ-014 fail_idx  output  4  index of the first failing vector; valid only when err_cnt>0.

Function
REQ-015 The block SHALL use the FSM states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-016 The block SHALL use a 4-bit vector index idx, with x_o=idx[3:2] and y_o=idx[1:0], stepping from 0 to 15 in ascending order.
REQ-017 When start=1 in IDLE or DONE, the block SHALL clear idx, err_cnt, fail_idx and done, set busy, and go to DRIVE.
REQ-018 When start=1 in DRIVE, WAIT or CHECK, the block SHALL ignore it; no restart and no counter change.
REQ-019 In DRIVE, the block SHALL register x_o/y_o from idx and go to WAIT.
REQ-020 In WAIT, the block SHALL hold x_o/y_o for exactly SETTLE cycles, then go to CHECK.
REQ-021 In CHECK, the block SHALL sample g_i/l_i/e_i and compare them to the expected values: g=(x>y), l=(x<y), e=(x==y), all unsigned.
REQ-022 Any bit mismatch, including multi-hot or all-zero results, SHALL count as one failing vector.
REQ-023 On a failing vector, the block SHALL increment err_cnt by 1; if this is the first failure, it SHALL load fail_idx=idx.
REQ-024 After CHECK: if idx=15, go to DONE; otherwise increment idx and go to DRIVE.
REQ-025 err_cnt SHALL NOT wrap; 5 bits covers the maximum of 16.
REQ-026 Latency from an accepted start to done=1 SHALL be exactly 16*(SETTLE+2) cycles; 48 cycles for SETTLE=1.
REQ-027 In DONE, the block SHALL hold busy=0 and done=1, keep err_cnt/fail_idx stable, and keep x_o/y_o at the last vector.

Reset
REQ-028 rst=1 SHALL force state=IDLE, idx=0, x_o=0, y_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0 on the next clock edge, including in the middle of a run.
REQ-029 rst SHALL take priority over start when both are asserted in the same cycle.
REQ-030 After reset, only a new start SHALL begin a run; a reset SHALL NOT resume an interrupted run.

Structure
REQ-031 A shared package cmp2_pkg SHALL hold the FSM state encoding, NUM_VEC=16 and the operand width of 2.
REQ-032 The expected-result logic SHALL be one combinational sub-module, cmp2_ref_model: inputs x, y; outputs g, l, e.
REQ-033 Everything else SHALL be registered; there SHALL be no combinational path from g_i/l_i/e_i to any output.

Verification
REQ-034 Correct twobit_comparator attached, SETTLE=1, start pulse -> done=1 after 48 cycles, pass=1, err_cnt=0.
REQ-035 e_i stuck at 0 -> err_cnt=4, fail_idx=0 (x=00,y=00), pass=0.
REQ-036 g_i and l_i swapped -> err_cnt=12, fail_idx=1 (x=00,y=01).
REQ-037 g_i, l_i and e_i all forced to 1 -> err_cnt=16, fail_idx=0, no wrap.
REQ-038 rst asserted while idx=7 -> all outputs at reset values next cycle; a new start runs the full 48 cycles with correct results.
REQ-039 start pulsed during WAIT -> ignored, completion still at cycle 48; start pulsed in DONE -> counters cleared, new run starts, SETTLE=3 run completes in 80 cycles.

Source files
------------

// File: rtl/cmp2_pkg.sv
// Shared definitions for the 2-bit comparator BIST: FSM encoding, vector count, widths.
package cmp2_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned IDX_W   = 2 * OP_W;
  localparam int unsigned ERR_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/cmp2_bist_if.sv
// Operand/result bus between the BIST engine and the comparator under test.
interface cmp2_bist_if;

  logic [cmp2_pkg::OP_W-1:0] x_o;
  logic [cmp2_pkg::OP_W-1:0] y_o;
  logic                      g_i;
  logic                      l_i;
  logic                      e_i;

  modport master (output x_o, y_o, input g_i, l_i, e_i);
  modport slave  (input x_o, y_o, output g_i, l_i, e_i);

endinterface

// File: rtl/cmp2_ref_model.sv
// Golden unsigned 2-bit comparison used to judge the comparator under test.
module cmp2_ref_model
  import cmp2_pkg::*;
(
  input  logic [OP_W-1:0] x,
  input  logic [OP_W-1:0] y,
  output logic            g,
  output logic            l,
  output logic            e
);

  assign g = (x > y);
  assign l = (x < y);
  assign e = (x == y);

endmodule

// File: rtl/cmp2_bist.sv
// Exhaustive self-test of a 2-bit comparator: drives all 16 operand pairs, waits SETTLE
// cycles per vector, and counts vectors whose g/l/e response differs from the golden model.
module cmp2_bist
  import cmp2_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  cmp2_bist_if.master       cmp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [IDX_W-1:0]  fail_idx
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         wait_q, wait_d;
  logic [OP_W-1:0]    x_q, x_d, y_q, y_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic               exp_g, exp_l, exp_e;
  logic               mismatch;

  cmp2_ref_model u_ref (
    .x (x_q),
    .y (y_q),
    .g (exp_g),
    .l (exp_l),
    .e (exp_e)
  );

  assign mismatch = ({cmp.g_i, cmp.l_i, cmp.e_i} != {exp_g, exp_l, exp_e});

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        x_d     = idx_q[IDX_W-1:OP_W];
        y_d     = idx_q[OP_W-1:0];
        wait_d  = 4'(SETTLE - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) state_d = CHECK;
        else              wait_d  = wait_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q == '0) fidx_d = idx_q;
          if (err_q < ERR_W'(NUM_VEC)) err_d = err_q + 1'b1;
        end
        // pass is registered alongside done, so it must see this vector's updated count
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign cmp.x_o  = x_q;
  assign cmp.y_o  = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_idx = fidx_q;

endmodule
